mem_access_ctrl: RTL and testbench

//  Processor-side initiator for the 64x32 RAM. Takes one-shot read/write requests from the

---
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Processor-side initiator for the 64x32 RAM: sequences address, select, read_w and data
// around one request, waits for MFC (with timeout) and returns read data with a done pulse.
module mem_access_ctrl #(
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 1,
  parameter int TIMEOUT       = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W:0]   mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              mem_read_w,
  input  logic              mem_MFC
);

  // state  | meaning
  // IDLE   | waiting for req; RAM deselected, read_w high
  // SETUP  | address/data settled; read select asserted, write select asserted on exit
  // ACCESS | select held, cycle counter running, waiting for MFC or timeout
  // DONE   | done/err pulse visible; lines hold, returns to IDLE

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [8:0] ACC_LIM = 9'(ACCESS_CYCLES);
  localparam logic [8:0] TO_LIM  = 9'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              read_w_q, read_w_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [8:0] cnt_inc;
  logic       acc_ok;
  logic       acc_to;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign acc_ok  = (state_q == S_ACCESS) && mem_MFC && (cnt_inc >= ACC_LIM);
  assign acc_to  = (state_q == S_ACCESS) && !acc_ok && (cnt_inc == TO_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= {1'b1, {ADDR_W{1'b0}}};
      data_in_q <= '0;
      read_w_q  <= 1'b1;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
      read_w_q  <= read_w_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (acc_ok || acc_to) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Address and data only move while read_w is high, so the RAM never sees a stray write.
  always_comb begin
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    data_in_d = data_in_q;
    read_w_d  = read_w_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d      = wr;
          addr_d    = {wr, addr};
          data_in_d = wdata;
          read_w_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_SETUP: begin
        cnt_d = '0;
        if (wr_q) begin
          addr_d[ADDR_W] = 1'b0;
          read_w_d       = 1'b0;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_inc[7:0];
        if (acc_ok || acc_to) begin
          addr_d[ADDR_W] = 1'b1;
          read_w_d       = 1'b1;
          done_d         = 1'b1;
          err_d          = acc_to;
          if (acc_ok && !wr_q) rdata_d = mem_dataOut;
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign rdata       = rdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign mem_address = addr_q;
  assign mem_dataIn  = data_in_q;
  assign mem_read_w  = read_w_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM model, directed vector table, reset-abort sequence and
// randomized transactions checked against a transaction-level timing model.
module tb_mem_access_ctrl;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int AC = 1;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          done, err, busy;
  logic [AW:0]   mem_address;
  logic [DW-1:0] mem_dataIn, mem_dataOut;
  logic          mem_read_w;
  logic          mem_MFC = 1'b0;

  logic [DW-1:0] ram [64] = '{default: '0};
  logic [DW-1:0] shadow [64];
  logic [DW-1:0] rd_exp;
  int            n_chk = 0;
  int            n_fail = 0;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            lat;   // ACCESS cycle (1-based) from which MFC is high
    bit            hold;  // keep req high into the next transaction
    int            dc;    // edges after accept edge at which done is seen
    bit            e;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut),
    .mem_read_w(mem_read_w), .mem_MFC(mem_MFC)
  );

  assign mem_dataOut = mem_address[AW] ? '0 : ram[mem_address[AW-1:0]];

  always @(posedge clk)
    if (!mem_address[AW] && !mem_read_w) ram[mem_address[AW-1:0]] <= mem_dataIn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Done arrives after the first ACCESS cycle k >= ACCESS_CYCLES with MFC, or at TIMEOUT.
  function automatic void model(input logic w, input logic [AW-1:0] a, input int lat,
                                output int dc, output bit e, output logic [DW-1:0] rd);
    int kd;
    e  = lat > TO;
    kd = e ? TO : ((lat > AC) ? lat : AC);
    dc = kd + 1;
    rd = (!w && !e) ? shadow[a] : rd_exp;
  endfunction

  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int lat, input bit hold, input int dc, input bit e,
                         input logic [DW-1:0] rd);
    req = 1'b1; wr = w; addr = a; wdata = d; mem_MFC = 1'($urandom);
    for (int c = 0; c <= dc + 1; c++) begin
      @(posedge clk); #1;
      chk("done", 64'(done), 64'(c == dc));
      chk("err", 64'(err), 64'((c == dc) && e));
      chk("busy", 64'(busy), 64'(c <= dc));
      chk("select_n", 64'(mem_address[AW]),
          64'(!((!w && c <= dc - 1) || (w && c >= 1 && c <= dc - 1))));
      chk("read_w", 64'(mem_read_w), 64'(!(w && c >= 1 && c <= dc - 1)));
      chk("mem_addr", 64'(mem_address[AW-1:0]), 64'(a));
      chk("mem_dataIn", 64'(mem_dataIn), 64'(d));
      chk("rdata", 64'(rdata), 64'((c >= dc) ? rd : rd_exp));
      if (c <= dc) begin
        mem_MFC = (c == 0 || c == dc) ? 1'($urandom) : (c >= lat);
        if (!hold) begin
          req = 1'($urandom); wr = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
        end
      end else begin
        req = hold;
        mem_MFC = 1'($urandom);
      end
    end
    rd_exp = rd;
    if (w) shadow[a] = d;
  endtask

  initial begin
    int dc;
    bit e;
    logic [DW-1:0] rd;
    logic w;
    logic [AW-1:0] a;
    int lat;
    bit hold;
    logic seen;

    for (int i = 0; i < 64; i++) shadow[i] = '0;
    rd_exp = '0;

    vecs[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 1,   1'b0, 2,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 6'd5,  32'h0,        1,   1'b0, 2,  1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 6'd9,  32'h0,        100, 1'b0, 16, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 6'd12, 32'h12345678, 4,   1'b0, 5,  1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 6'd12, 32'h0,        4,   1'b0, 5,  1'b0, 32'h12345678};
    vecs[5]  = '{1'b1, 6'd0,  32'hA5A5A5A5, 1,   1'b1, 2,  1'b0, 32'h12345678};
    vecs[6]  = '{1'b1, 6'd63, 32'h5A5A5A5A, 1,   1'b1, 2,  1'b0, 32'h12345678};
    vecs[7]  = '{1'b0, 6'd0,  32'h0,        1,   1'b0, 2,  1'b0, 32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 6'd63, 32'h0,        2,   1'b0, 3,  1'b0, 32'h5A5A5A5A};
    vecs[9]  = '{1'b1, 6'd20, 32'hCAFEF00D, 15,  1'b0, 16, 1'b0, 32'h5A5A5A5A};
    vecs[10] = '{1'b1, 6'd21, 32'h0BADF00D, 16,  1'b0, 16, 1'b1, 32'h5A5A5A5A};
    vecs[11] = '{1'b0, 6'd20, 32'h0,        15,  1'b0, 16, 1'b0, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 6'd21, 32'h0,        3,   1'b0, 4,  1'b0, 32'h0BADF00D};

    repeat (3) begin
      req = 1'($urandom); wr = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
      mem_MFC = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_mem_address", 64'(mem_address), 64'(7'h40));
      chk("rst_read_w", 64'(mem_read_w), 64'd1);
      chk("rst_dataIn", 64'(mem_dataIn), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_done_err_busy", 64'({done, err, busy}), 64'd0);
    end
    req = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].hold,
              vecs[i].dc, vecs[i].e, vecs[i].rd);

    // Reset during a write ACCESS abandons the access with no done pulse.
    req = 1'b1; wr = 1'b1; addr = 6'd40; wdata = 32'h11112222; mem_MFC = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_access_sel", 64'(mem_address[AW]), 64'd0);
    chk("abort_in_access_rw", 64'(mem_read_w), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_read_w", 64'(mem_read_w), 64'd1);
    chk("abort_select_n", 64'(mem_address[AW]), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done_err", 64'({done, err}), 64'd0);
    chk("abort_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    shadow[40] = 32'h11112222;
    rd_exp = '0;
    seen = 1'b0;
    repeat (20) begin
      mem_MFC = 1'($urandom);
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    for (int n = 0; n < 200; n++) begin
      w    = 1'($urandom);
      a    = AW'($urandom);
      lat  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 5));
      hold = ($urandom_range(0, 3) == 0);
      model(w, a, lat, dc, e, rd);
      run_txn(w, a, $urandom, lat, hold, dc, e, rd);
    end
    req = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) chk("ram_word", 64'(ram[i]), 64'(shadow[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
